// File: rtl/occ_pkg.sv
// Shared constants for the Occ lookup arbiter: nucleotide codes, field width,
// the row -1 address and the arbiter FSM state encoding.
package occ_pkg;

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  localparam int OCC_FIELD_W = 8;

  // Row -1 of the Occ table; the ROM returns an all-zero word here.
  localparam logic [7:0] OCC_ADDR_NEG1 = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } occ_state_e;

endpackage

// File: rtl/occ_lookup_arbiter_if.sv
// Lane request/response bundle plus the Occ ROM port of the lookup arbiter.
// master = lanes + ROM side, slave = arbiter.
interface occ_lookup_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*2-1:0]      req_nt;
  logic [NUM_REQ-1:0]        req_ready;

  logic [NUM_REQ-1:0]        rsp_valid;
  logic [CNT_W-1:0]          rsp_cnt;
  logic [DATA_W-1:0]         rsp_occ;
  logic                      rsp_err;

  logic                      rom_ce;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rom_valid;

  modport master (
    output req_valid, req_addr, req_nt, rom_data, rom_valid,
    input  req_ready, rsp_valid, rsp_cnt, rsp_occ, rsp_err, rom_ce, rom_addr
  );

  modport slave (
    input  req_valid, req_addr, req_nt, rom_data, rom_valid,
    output req_ready, rsp_valid, rsp_cnt, rsp_occ, rsp_err, rom_ce, rom_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, scanning upward and wrapping. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/occ_lookup_arbiter.sv
// Shares one combinational Occ ROM between NUM_REQ backward-search lanes:
// round-robin grant, one-cycle ROM read, one-cycle response pulse to the lane.
module occ_lookup_arbiter
  import occ_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = OCC_FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  occ_lookup_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  occ_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   lat_g;
  logic [1:0]         lat_nt;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant_ok;
  logic               grant;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Gating with rst keeps a lane from seeing a handshake the FSM will not take.
  assign grant_ok      = (state == ST_IDLE) && !rst;
  assign grant         = grant_ok && (|bus.req_valid);
  assign bus.req_ready = grant_ok ? gnt : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      lat_g         <= '0;
      lat_nt        <= '0;
      bus.rom_ce    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_cnt   <= '0;
      bus.rsp_occ   <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            lat_g        <= gnt_idx;
            lat_nt       <= bus.req_nt[int'(gnt_idx)*2 +: 2];
            bus.rom_ce   <= 1'b1;
            bus.rom_addr <= bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            ptr          <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            state        <= ST_READ;
          end
        end
        ST_READ: begin
          // A read with rom_valid low is reported as an error with zeroed data.
          bus.rsp_err        <= ~bus.rom_valid;
          bus.rsp_occ        <= bus.rom_valid ? bus.rom_data : '0;
          bus.rsp_cnt        <= bus.rom_valid ? bus.rom_data[int'(lat_nt)*CNT_W +: CNT_W] : '0;
          bus.rsp_valid[lat_g] <= 1'b1;
          bus.rom_ce         <= 1'b0;
          bus.rom_addr       <= '0;
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
